// File: rtl/reference_reader_if.sv
// Bus bundle for reference_reader: read request/return port towards the
// reference sample buffer and the valid/ready I/Q stream towards the correlator.
interface reference_reader_if #(
   parameter int index_bits = 4,
   parameter int i_bits     = 12,
   parameter int q_bits     = 12
);
   logic [index_bits-1:0]    rd_addr;
   logic                     rd_addr_valid;
   logic                     rd_data_ready;
   logic signed [i_bits-1:0] rd_i;
   logic signed [q_bits-1:0] rd_q;
   logic                     rd_data_valid;
   logic signed [i_bits-1:0] out_i;
   logic signed [q_bits-1:0] out_q;
   logic                     out_valid;
   logic                     out_ready;
   logic                     out_last;

   modport master (
      output rd_addr, rd_addr_valid, rd_data_ready, out_i, out_q, out_valid, out_last,
      input  rd_i, rd_q, rd_data_valid, out_ready
   );

   modport slave (
      input  rd_addr, rd_addr_valid, rd_data_ready, out_i, out_q, out_valid, out_last,
      output rd_i, rd_q, rd_data_valid, out_ready
   );
endinterface

// File: rtl/reference_reader.sv
// Sweeps the reference buffer from a programmable offset (wrapping at buffer_length)
// and streams the returned I/Q samples through a credit-protected output FIFO.
// Optional feature: define REF_READER_CONJ_EN to emit the saturated conjugate (out_q = -rd_q).
module reference_reader #(
   parameter int buffer_length = 10,
   parameter int index_bits    = 4,
   parameter int i_bits        = 12,
   parameter int q_bits        = 12,
   parameter int fifo_depth    = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [index_bits-1:0] offset,
   input  logic [index_bits:0]   count,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   reference_reader_if.master    bus
);
   localparam int ptr_bits = $clog2(fifo_depth);
   localparam int occ_bits = ptr_bits + 1;

   localparam logic [index_bits:0]   len_c   = (index_bits+1)'(buffer_length);
   localparam logic [index_bits-1:0] top_c   = index_bits'(buffer_length - 1);
   localparam logic [index_bits-1:0] idx_one = index_bits'(1);
   localparam logic [index_bits:0]   cnt_one = (index_bits+1)'(1);
   localparam logic [occ_bits-1:0]   occ_one = occ_bits'(1);
   localparam logic [ptr_bits-1:0]   ptr_one = ptr_bits'(1);
   localparam logic [occ_bits:0]     depth_c = (occ_bits+1)'(fifo_depth);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   typedef struct packed {
      logic signed [i_bits-1:0] i;
      logic signed [q_bits-1:0] q;
      logic                     last;
   } entry_t;

   state_t                   state_q, state_nxt;
   logic [index_bits-1:0]    addr_q;
   logic [index_bits:0]      count_q, issued_q, returned_q;
   logic [occ_bits-1:0]      outstanding_q, fifo_count_q;
   logic [ptr_bits-1:0]      wr_ptr_q, rd_ptr_q;
   entry_t                   mem [fifo_depth];
   entry_t                   head, push_entry;
   logic signed [q_bits-1:0] push_q;
   logic [occ_bits:0]        in_flight;
   logic                     load, issue, push, pop, has_data;
   logic                     busy_nxt, done_nxt, err_nxt;

   // Credits: every issued request already owns a FIFO slot, so returns never stall.
   assign in_flight = {1'b0, outstanding_q} + {1'b0, fifo_count_q};
   assign has_data  = (fifo_count_q != '0);
   assign push      = bus.rd_data_valid && (outstanding_q != '0);
   assign pop       = has_data && bus.out_ready;

`ifdef REF_READER_CONJ_EN
   localparam logic signed [q_bits-1:0] q_min = {1'b1, {(q_bits-1){1'b0}}};
   localparam logic signed [q_bits-1:0] q_max = {1'b0, {(q_bits-1){1'b1}}};
   assign push_q = (bus.rd_q == q_min) ? q_max : -bus.rd_q;
`else
   assign push_q = bus.rd_q;
`endif

   assign push_entry.i    = bus.rd_i;
   assign push_entry.q    = push_q;
   assign push_entry.last = ((returned_q + cnt_one) == count_q);

   // NOTE: every output of this block gets a default before the case statement,
   // so no path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state_q;
      load      = 1'b0;
      issue     = 1'b0;
      busy_nxt  = busy;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (({1'b0, offset} >= len_c) || (count > len_c)) begin
                  err_nxt = 1'b1;
               end else if (count == '0) begin
                  done_nxt = 1'b1;
               end else begin
                  load      = 1'b1;
                  busy_nxt  = 1'b1;
                  state_nxt = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (in_flight < depth_c) begin
               issue = 1'b1;
               if ((issued_q + cnt_one) == count_q) state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if ((outstanding_q == '0) && !has_data) begin
               done_nxt  = 1'b1;
               busy_nxt  = 1'b0;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge value of every other register, whatever the block order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         state_q <= state_nxt;
         busy    <= busy_nxt;
         done    <= done_nxt;
         err     <= err_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q        <= '0;
         count_q       <= '0;
         issued_q      <= '0;
         returned_q    <= '0;
         outstanding_q <= '0;
         fifo_count_q  <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
      end else begin
         if (load) begin
            addr_q     <= offset;
            count_q    <= count;
            issued_q   <= '0;
            returned_q <= '0;
         end else begin
            if (issue) begin
               addr_q   <= (addr_q == top_c) ? '0 : addr_q + idx_one;
               issued_q <= issued_q + cnt_one;
            end
            if (push) returned_q <= returned_q + cnt_one;
         end

         case ({issue, push})
            2'b10:   outstanding_q <= outstanding_q + occ_one;
            2'b01:   outstanding_q <= outstanding_q - occ_one;
            default: outstanding_q <= outstanding_q;
         endcase

         if (push) wr_ptr_q <= wr_ptr_q + ptr_one;
         if (pop)  rd_ptr_q <= rd_ptr_q + ptr_one;

         case ({push, pop})
            2'b10:   fifo_count_q <= fifo_count_q + occ_one;
            2'b01:   fifo_count_q <= fifo_count_q - occ_one;
            default: fifo_count_q <= fifo_count_q;
         endcase
      end
   end

   // NOTE: FIFO storage is deliberately not reset; the stream outputs are gated
   // by occupancy, so a stale entry can never become visible.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= push_entry;
   end

   assign head              = mem[rd_ptr_q];
   assign bus.out_valid     = has_data;
   assign bus.out_i         = has_data ? head.i : '0;
   assign bus.out_q         = has_data ? head.q : '0;
   assign bus.out_last      = has_data && head.last;
   assign bus.rd_addr       = addr_q;
   assign bus.rd_addr_valid = issue;
   assign bus.rd_data_ready = 1'b1;
endmodule

// File: tb/tb_reference_reader.sv
// Self-checking bench for reference_reader: table-driven sweeps, directed corner
// cases and randomized sweeps scored against a sample-level model of the buffer.
module tb_reference_reader;
   localparam int buffer_length = 10;
   localparam int index_bits    = 4;
   localparam int i_bits        = 12;
   localparam int q_bits        = 12;
   localparam int fifo_depth    = 4;

   typedef struct {
      logic signed [i_bits-1:0] i;
      logic signed [q_bits-1:0] q;
      logic                     last;
   } sample_t;

   typedef struct {
      logic [index_bits-1:0] offset;
      logic [index_bits:0]   count;
      int                    stall;
      bit                    poke;
      bit                    exp_err;
      bit                    exp_zero;
   } vec_t;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic                  start = 1'b0;
   logic [index_bits-1:0] offset = '0;
   logic [index_bits:0]   count = '0;
   logic                  busy, done, err;

   reference_reader_if #(.index_bits(index_bits), .i_bits(i_bits), .q_bits(q_bits)) bus ();

   reference_reader #(
      .buffer_length(buffer_length), .index_bits(index_bits),
      .i_bits(i_bits), .q_bits(q_bits), .fifo_depth(fifo_depth)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .offset(offset), .count(count),
      .busy(busy), .done(done), .err(err), .bus(bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int req_total = 0;
   int pop_total = 0;
   int first_req_cyc, last_req_cyc, first_pop_cyc, last_pop_cyc;
   bit rand_ready = 1'b0;
   bit stray = 1'b0;

   logic signed [i_bits-1:0] mem_i [16];
   logic signed [q_bits-1:0] mem_q [16];
   sample_t                  exp_q [$];
   logic [index_bits-1:0]    exp_addr [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic at_pos();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
      #1;
   endtask

   function automatic logic signed [q_bits-1:0] model_q(input logic signed [q_bits-1:0] q);
      int v;
      v = int'(q);
`ifdef REF_READER_CONJ_EN
      v = -v;
      if (v > 2**(q_bits-1) - 1) v = 2**(q_bits-1) - 1;
`endif
      return q_bits'(v);
   endfunction

   // Reference model: a sweep is just count consecutive buffer slots modulo the length.
   task automatic expect_sweep(input int off, input int cnt);
      sample_t s;
      for (int k = 0; k < cnt; k++) begin
         int a;
         a = (off + k) % buffer_length;
         exp_addr.push_back(index_bits'(a));
         s.i    = mem_i[a];
         s.q    = model_q(mem_q[a]);
         s.last = (k == cnt - 1);
         exp_q.push_back(s);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, ".busy"}, busy, 0);
      check({tag, ".done"}, done, 0);
      check({tag, ".err"}, err, 0);
      check({tag, ".rd_addr_valid"}, bus.rd_addr_valid, 0);
      check({tag, ".rd_addr"}, bus.rd_addr, 0);
      check({tag, ".out_valid"}, bus.out_valid, 0);
      check({tag, ".out_last"}, bus.out_last, 0);
      check({tag, ".out_i"}, bus.out_i, 0);
      check({tag, ".out_q"}, bus.out_q, 0);
   endtask

   // Reference buffer: a request seen in cycle n is answered in cycle n+2.
   logic                  d1_v = 1'b0, d2_v = 1'b0;
   logic [index_bits-1:0] d1_a = '0, d2_a = '0;
   always @(negedge clk) begin
      bus.rd_data_valid = d2_v | stray;
      bus.rd_i = d2_v ? mem_i[d2_a] : 12'sh5a5;
      bus.rd_q = d2_v ? mem_q[d2_a] : 12'sh3c3;
      d2_v = d1_v;
      d2_a = d1_a;
      d1_v = bus.rd_addr_valid;
      d1_a = bus.rd_addr;
   end

   always @(posedge clk) cyc++;

   bit                       prev_hold = 1'b0;
   logic signed [i_bits-1:0] prev_i;
   logic signed [q_bits-1:0] prev_q;
   logic                     prev_last;

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.rd_addr_valid) begin
            req_total++;
            if (first_req_cyc < 0) first_req_cyc = cyc;
            last_req_cyc = cyc;
            if (exp_addr.size() == 0) check("unexpected_req", bus.rd_addr_valid, 1'b0);
            else check("rd_addr", bus.rd_addr, exp_addr.pop_front());
            checks++;
            if (req_total - pop_total > fifo_depth) begin
               failures++;
               $display("FAIL credit: in_flight=%0d limit=%0d", req_total - pop_total, fifo_depth);
            end
         end
         if (prev_hold) begin
            check("hold_valid", bus.out_valid, 1'b1);
            check("hold_data", {bus.out_i, bus.out_q, bus.out_last}, {prev_i, prev_q, prev_last});
         end
         if (bus.out_valid && bus.out_ready) begin
            pop_total++;
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
            last_pop_cyc = cyc;
            if (exp_q.size() == 0) begin
               check("unexpected_out", bus.out_valid, 1'b0);
            end else begin
               sample_t s;
               s = exp_q.pop_front();
               check("out_i", bus.out_i, s.i);
               check("out_q", bus.out_q, s.q);
               check("out_last", bus.out_last, s.last);
            end
         end
         prev_hold = bus.out_valid && !bus.out_ready;
         prev_i    = bus.out_i;
         prev_q    = bus.out_q;
         prev_last = bus.out_last;
      end
   end

   task automatic run_sweep(input vec_t v);
      int  req0, pop0, stall_left;
      bit  got_done, busy_ok;
      req0 = req_total;
      pop0 = pop_total;
      first_req_cyc = -1;
      first_pop_cyc = -1;
      if (!v.exp_err && !v.exp_zero) expect_sweep(int'(v.offset), int'(v.count));
      offset = v.offset;
      count  = v.count;
      start  = 1'b1;
      at_pos();
      start  = 1'b0;
      offset = index_bits'($urandom);
      count  = (index_bits+1)'($urandom);
      at_neg();
      check("start_err", err, v.exp_err);
      check("start_done", done, v.exp_zero);
      check("start_busy", busy, !(v.exp_err || v.exp_zero));
      if (v.exp_err || v.exp_zero) begin
         repeat (6) at_neg();
         check("idle_no_req", req_total, req0);
         check("idle_no_out", pop_total, pop0);
         check("idle_busy", busy, 0);
         return;
      end
      stall_left = v.stall;
      got_done   = 1'b0;
      busy_ok    = 1'b1;
      for (int c = 0; c < 400 && !got_done; c++) begin
         at_pos();
         start = (v.poke && c == 2);
         if (v.poke && c == 2) begin
            offset = index_bits'(buffer_length);
            count  = (index_bits+1)'(2);
         end
         if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
         else if (stall_left > 0 && pop_total > pop0) begin
            bus.out_ready = 1'b0;
            stall_left--;
         end else bus.out_ready = 1'b1;
         at_neg();
         if (v.poke && c == 3) check("busy_start_ignored", err, 0);
         if (done) got_done = 1'b1;
         else if (!busy) busy_ok = 1'b0;
      end
      check("done_seen", got_done, 1'b1);
      check("busy_through_sweep", busy_ok, 1'b1);
      check("busy_at_done", busy, 0);
      check("sample_count", pop_total - pop0, v.count);
      check("request_count", req_total - req0, v.count);
      check("queue_drained", exp_q.size(), 0);
      if (v.stall == 0 && !rand_ready) begin
         check("issue_back_to_back", last_req_cyc - first_req_cyc, v.count - 1);
         check("out_back_to_back", last_pop_cyc - first_pop_cyc, v.count - 1);
      end
      at_neg();
      check("done_one_cycle", done, 0);
      exp_q.delete();
      exp_addr.delete();
      bus.out_ready = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   vec_t tbl [8];

   initial begin
      vec_t v;
      int   pop0;

      tbl[0] = '{4'd0,  5'd10, 0, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{4'd7,  5'd6,  0, 1'b1, 1'b0, 1'b0};
      tbl[2] = '{4'd3,  5'd10, 8, 1'b0, 1'b0, 1'b0};
      tbl[3] = '{4'd0,  5'd0,  0, 1'b0, 1'b0, 1'b1};
      tbl[4] = '{4'd10, 5'd3,  0, 1'b0, 1'b1, 1'b0};
      tbl[5] = '{4'd2,  5'd11, 0, 1'b0, 1'b1, 1'b0};
      tbl[6] = '{4'd9,  5'd1,  0, 1'b0, 1'b0, 1'b0};
      tbl[7] = '{4'd4,  5'd2,  0, 1'b0, 1'b0, 1'b0};

      for (int a = 0; a < 16; a++) begin
         mem_i[a] = i_bits'($urandom);
         mem_q[a] = q_bits'($urandom);
      end
      mem_q[4] = -12'sd2048;
      mem_q[5] = 12'sd5;
      mem_q[6] = 12'sd2047;

      bus.out_ready     = 1'b1;
      bus.rd_data_valid = 1'b0;
      bus.rd_i          = '0;
      bus.rd_q          = '0;

      at_pos();
      at_pos();
      check_zero("reset");
      rst_n = 1'b1;
      at_neg();
      check("rd_data_ready", bus.rd_data_ready, 1'b1);
      check_zero("idle_after_reset");

      for (int t = 0; t < 8; t++) run_sweep(tbl[t]);

      // Return strobe with nothing outstanding must be dropped.
      at_pos();
      stray = 1'b1;
      at_pos();
      stray = 1'b0;
      repeat (3) begin
         at_neg();
         check("stray_ignored", bus.out_valid, 1'b0);
      end

      // Asynchronous reset in the middle of a sweep, with returns still in flight.
      expect_sweep(0, 10);
      offset = '0;
      count  = (index_bits+1)'(10);
      start  = 1'b1;
      at_pos();
      start  = 1'b0;
      pop0   = pop_total;
      for (int c = 0; c < 100 && (pop_total - pop0) < 4; c++) at_neg();
      check("pops_before_reset", pop_total - pop0, 4);
      #1 rst_n = 1'b0;
      #1 check_zero("mid_sweep_reset");
      exp_q.delete();
      exp_addr.delete();
      req_total = 0;
      pop_total = 0;
      prev_hold = 1'b0;
      at_pos();
      rst_n = 1'b1;
      repeat (4) begin
         at_neg();
         check("post_reset_quiet", {bus.out_valid, busy}, 2'b00);
      end
      v = '{4'd0, 5'd3, 0, 1'b0, 1'b0, 1'b0};
      run_sweep(v);

      rand_ready = 1'b1;
      for (int r = 0; r < 25; r++) begin
         v.offset   = index_bits'($urandom_range(0, 11));
         v.count    = (index_bits+1)'($urandom_range(0, 11));
         v.stall    = 0;
         v.exp_err  = (int'(v.offset) >= buffer_length) || (int'(v.count) > buffer_length);
         v.exp_zero = !v.exp_err && (v.count == '0);
         v.poke     = !v.exp_err && (int'(v.count) >= 4) && (r % 4 == 0);
         run_sweep(v);
      end
      rand_ready    = 1'b0;
      bus.out_ready = 1'b1;

      repeat (2) at_neg();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
